// File: rtl/adder_cla_pipe_pkg.sv
// -----------------------------------------------------------------------------
// adder_cla_pipe_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor:
//   - default widths and stage count
//   - operation mode encoding (add / subtract)
//   - helpers for the derived segment width and parameter legality
// -----------------------------------------------------------------------------
package adder_cla_pipe_pkg;

  localparam int DEF_BW_DATA = 32;
  localparam int DEF_NSTAGE  = 4;
  localparam int DEF_BW_GRP  = 4;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // Width of the operand slice handled by one pipeline stage.
  function automatic int seg_width(input int bw_data, input int nstage);
    return (nstage < 1) ? 1 : bw_data / nstage;
  endfunction

  // True when the operand splits evenly into stages and each stage's slice
  // splits evenly into lookahead groups.
  function automatic bit params_ok(input int bw_data, input int nstage, input int bw_grp);
    if (nstage < 1 || bw_grp < 1 || bw_data < 1) return 1'b0;
    if (bw_data % nstage != 0) return 1'b0;
    return ((bw_data / nstage) % bw_grp) == 0;
  endfunction

endpackage

// File: rtl/adder_cla_pipe_if.sv
// -----------------------------------------------------------------------------
// adder_cla_pipe_if
// Operand-side and result-side valid/ready channels of adder_cla_pipe.
//   master : upstream/downstream environment (drives operands and i_rdy)
//   slave  : the adder (drives o_rdy and the result)
// Signals:
//   i_vld/o_rdy          operand handshake
//   i_a/i_b/i_c/i_sub    operands, carry/borrow-in, mode (0 add, 1 sub)
//   o_vld/i_rdy          result handshake
//   o_s/o_c/o_ovf        sum/difference, carry-out, signed overflow
// -----------------------------------------------------------------------------
interface adder_cla_pipe_if
  import adder_cla_pipe_pkg::*;
#(
  parameter int BW_DATA = DEF_BW_DATA
) ();

  logic               i_vld;
  logic               o_rdy;
  logic [BW_DATA-1:0] i_a;
  logic [BW_DATA-1:0] i_b;
  logic               i_c;
  logic               i_sub;
  logic               o_vld;
  logic               i_rdy;
  logic [BW_DATA-1:0] o_s;
  logic               o_c;
  logic               o_ovf;

  modport master (
    output i_vld, i_a, i_b, i_c, i_sub, i_rdy,
    input  o_rdy, o_vld, o_s, o_c, o_ovf
  );

  modport slave (
    input  i_vld, i_a, i_b, i_c, i_sub, i_rdy,
    output o_rdy, o_vld, o_s, o_c, o_ovf
  );

endinterface

// File: rtl/adder_cla_pipe_seg.sv
// -----------------------------------------------------------------------------
// cla_seg
// Combinational carry-lookahead adder for one BW_SEG-wide segment, built from
// BW_GRP-wide lookahead groups with a second lookahead level across groups.
// Ports:
//   a, b  segment operands (b already conditioned for subtraction)
//   cin   carry into the segment's LSB
//   s     segment sum
//   cout  carry out of the segment's MSB
//   cmsb  carry into the segment's MSB (cout ^ cmsb is signed overflow when
//         this is the top segment)
// -----------------------------------------------------------------------------
module cla_seg #(
  parameter int BW_SEG = 8,
  parameter int BW_GRP = 4
) (
  input  logic [BW_SEG-1:0] a,
  input  logic [BW_SEG-1:0] b,
  input  logic              cin,
  output logic [BW_SEG-1:0] s,
  output logic              cout,
  output logic              cmsb
);

  localparam int NG = BW_SEG / BW_GRP;

  logic [BW_SEG-1:0] g;
  logic [BW_SEG-1:0] p;
  logic [NG-1:0]     gg;
  logic [NG-1:0]     gp;
  logic [NG:0]       gc;
  logic [BW_SEG:0]   c;
  logic              term;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is written as an explicit sum of products (generate term
  // ANDed with all propagates above it), so no carry depends on another
  // carry of the same level.
  // NOTE: every signal written here gets a value before any conditional
  // or loop touches it, so no path leaves it unassigned and no latch forms.
  always_comb begin
    gg   = '0;
    gp   = '0;
    gc   = '0;
    c    = '0;
    term = 1'b0;

    // Group generate / propagate.
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*BW_GRP +: BW_GRP];
      for (int i = 0; i < BW_GRP; i++) begin
        term = g[j*BW_GRP + i];
        for (int m = i + 1; m < BW_GRP; m++) term = term & p[j*BW_GRP + m];
        gg[j] = gg[j] | term;
      end
    end

    // Carry into each group (gc[NG] is the segment carry-out).
    for (int j = 0; j <= NG; j++) begin
      term = cin;
      for (int m = 0; m < j; m++) term = term & gp[m];
      gc[j] = term;
      for (int i = 0; i < j; i++) begin
        term = gg[i];
        for (int m = i + 1; m < j; m++) term = term & gp[m];
        gc[j] = gc[j] | term;
      end
    end

    // Carry into each bit, looked ahead from its group's carry-in.
    for (int j = 0; j < NG; j++) begin
      for (int i = 0; i < BW_GRP; i++) begin
        term = gc[j];
        for (int m = 0; m < i; m++) term = term & p[j*BW_GRP + m];
        c[j*BW_GRP + i] = term;
        for (int q = 0; q < i; q++) begin
          term = g[j*BW_GRP + q];
          for (int m = q + 1; m < i; m++) term = term & p[j*BW_GRP + m];
          c[j*BW_GRP + i] = c[j*BW_GRP + i] | term;
        end
      end
    end
    c[BW_SEG] = gc[NG];
  end

  assign s    = p ^ c[BW_SEG-1:0];
  assign cout = c[BW_SEG];
  assign cmsb = c[BW_SEG-1];

endmodule

// File: rtl/adder_cla_pipe.sv
// -----------------------------------------------------------------------------
// adder_cla_pipe
// Pipelined carry-lookahead adder/subtractor. The operands are split into
// NSTAGE segments; stage k adds segment k using the carry registered by stage
// k-1. Latency NSTAGE, throughput one result per cycle, one global enable
// (en = !o_vld || i_rdy) stalls the whole pipe under backpressure.
// Ports:
//   i_clk  rising-edge clock
//   i_rst  synchronous active-high reset
//   bus    operand and result valid/ready channels (slave side)
// -----------------------------------------------------------------------------
module adder_cla_pipe
  import adder_cla_pipe_pkg::*;
#(
  parameter int BW_DATA = DEF_BW_DATA,
  parameter int NSTAGE  = DEF_NSTAGE,
  parameter int BW_GRP  = DEF_BW_GRP
) (
  input  logic            i_clk,
  input  logic            i_rst,
  adder_cla_pipe_if.slave bus
);

  localparam int BW_SEG = seg_width(BW_DATA, NSTAGE);

  if (!params_ok(BW_DATA, NSTAGE, BW_GRP)) begin : g_bad_params
    $error("adder_cla_pipe: BW_DATA must split into NSTAGE segments that split into BW_GRP groups");
  end

  mode_e              mode;
  logic [BW_DATA-1:0] b_eff;
  logic               cin_eff;
  logic               en;

  // Subtraction is A + ~B + ~borrow_in, so i_c keeps borrow meaning in sub mode.
  assign mode    = mode_e'(bus.i_sub);
  assign b_eff   = (mode == MODE_SUB) ? ~bus.i_b : bus.i_b;
  assign cin_eff = bus.i_c ^ (mode == MODE_SUB);

  // Stage inputs and registers. w carries A with the finished sum segments
  // written over it in place; b carries conditioned B. Bits already consumed
  // or not yet needed simply ride along and are pruned by synthesis.
  logic [BW_DATA-1:0] w_in  [NSTAGE];
  logic [BW_DATA-1:0] b_in  [NSTAGE];
  logic               c_in  [NSTAGE];
  logic               v_in  [NSTAGE];
  logic [BW_DATA-1:0] w_q   [NSTAGE];
  logic [BW_DATA-1:0] b_q   [NSTAGE];
  logic               c_q   [NSTAGE];
  logic               ovf_q [NSTAGE];
  logic               v_q   [NSTAGE];

  assign en        = !v_q[NSTAGE-1] || bus.i_rdy;
  assign bus.o_rdy = en;
  assign bus.o_vld = v_q[NSTAGE-1];
  assign bus.o_s   = w_q[NSTAGE-1];
  assign bus.o_c   = c_q[NSTAGE-1];
  assign bus.o_ovf = ovf_q[NSTAGE-1];

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    logic [BW_SEG-1:0]  seg_s;
    logic               seg_cout;
    logic               seg_cmsb;
    logic [BW_DATA-1:0] w_nxt;

    if (k == 0) begin : g_head
      assign w_in[k] = bus.i_a;
      assign b_in[k] = b_eff;
      assign c_in[k] = cin_eff;
      assign v_in[k] = bus.i_vld;
    end else begin : g_body
      assign w_in[k] = w_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign v_in[k] = v_q[k-1];
    end

    cla_seg #(
      .BW_SEG (BW_SEG),
      .BW_GRP (BW_GRP)
    ) u_seg (
      .a    (w_in[k][k*BW_SEG +: BW_SEG]),
      .b    (b_in[k][k*BW_SEG +: BW_SEG]),
      .cin  (c_in[k]),
      .s    (seg_s),
      .cout (seg_cout),
      .cmsb (seg_cmsb)
    );

    always_comb begin
      w_nxt = w_in[k];
      w_nxt[k*BW_SEG +: BW_SEG] = seg_s;
    end

    // Data registers load only for valid entries, so a bubble reaching the
    // last stage leaves o_s/o_c/o_ovf at the previous result. ovf_q is only
    // meaningful in the last stage, where seg_cmsb is the carry into the MSB.
    // NOTE: state updates use non-blocking assignments so every stage samples
    // its predecessor's pre-edge value regardless of block evaluation order.
    // NOTE: the data registers are reset too, because the last stage drives
    // the result outputs directly and those must read zero after reset.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        v_q[k]   <= 1'b0;
        w_q[k]   <= '0;
        b_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        ovf_q[k] <= 1'b0;
      end else if (en) begin
        v_q[k] <= v_in[k];
        if (v_in[k]) begin
          w_q[k]   <= w_nxt;
          b_q[k]   <= b_in[k];
          c_q[k]   <= seg_cout;
          ovf_q[k] <= seg_cout ^ seg_cmsb;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_cla_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_cla_pipe
// Self-checking bench for adder_cla_pipe (32-bit, 4 stages, 4-bit groups).
// Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_adder_cla_pipe;
  import adder_cla_pipe_pkg::*;

  localparam int     BW   = 32;
  localparam int     NST  = 4;
  localparam int     GRP  = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        sub;
    res_t        r;
  } dir_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_cla_pipe_if #(.BW_DATA(BW)) bus ();

  adder_cla_pipe #(
    .BW_DATA (BW),
    .NSTAGE  (NST),
    .BW_GRP  (GRP)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  res_t exp_q[$];
  res_t got_q[$];
  int   acc_cyc[$];
  int   out_cyc[$];

  // Reference: signed overflow is the true signed result leaving the 32-bit
  // range; carry for subtraction means "no borrow", i.e. a >= b + c.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic c, input logic sub);
    res_t        r;
    logic [32:0] u;
    longint      sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sub) begin
      r.s = a - b - 32'(c);
      r.c = ({1'b0, a} >= ({1'b0, b} + 33'(c)));
      sr  = sa - sb - longint'(c);
    end else begin
      u   = {1'b0, a} + {1'b0, b} + 33'(c);
      r.s = u[31:0];
      r.c = u[32];
      sr  = sa + sb + longint'(c);
    end
    r.ovf = (sr > SMAX) || (sr < SMIN);
    return r;
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h0000_0000;
      default: return $urandom();
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic sub, input logic vld);
    bus.i_a   = a;
    bus.i_b   = b;
    bus.i_c   = c;
    bus.i_sub = sub;
    bus.i_vld = vld;
  endtask

  task automatic drive_rand(input logic vld);
    drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), vld);
  endtask

  // One clock cycle: record transfers seen at the falling edge, then step
  // past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst) begin
      if (bus.i_vld && bus.o_rdy) begin
        exp_q.push_back(model(bus.i_a, bus.i_b, bus.i_c, bus.i_sub));
        acc_cyc.push_back(cyc);
      end
      if (bus.o_vld && bus.i_rdy) begin
        got_q.push_back(res_t'({bus.o_s, bus.o_c, bus.o_ovf}));
        out_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_results(input int n, input int budget);
    for (int k = 0; k < budget && got_q.size() < n; k++) tick();
  endtask

  task automatic clear();
    exp_q.delete();
    got_q.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_rdy = 1'b1;
    drive(32'd5, 32'd3, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    n_cmp++;
    if ({bus.o_vld, bus.o_s, bus.o_c, bus.o_ovf} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_outputs got vld=%b s=%h c=%b ovf=%b exp all 0",
               bus.o_vld, bus.o_s, bus.o_c, bus.o_ovf);
    end
    rst = 1'b0;
    bus.i_vld = 1'b0;
    #1;
    n_cmp++;
    if (bus.o_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_o_rdy got %b exp 1", bus.o_rdy);
    end
    clear();
    for (int k = 0; k < 8; k++) tick();
    n_cmp++;
    if (got_q.size() != 0 || bus.o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_emit got %0d results vld=%b exp 0 results vld=0",
               got_q.size(), bus.o_vld);
    end
  endtask

  task automatic test_directed();
    dir_t tbl [10];
    tbl = '{
      '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h0000_0000, 1'b1, 1'b0}},
      '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, '{32'hFFFF_FFFE, 1'b0, 1'b0}},
      '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, '{32'h7FFF_FFFF, 1'b1, 1'b1}},
      '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, '{32'h8000_0000, 1'b0, 1'b1}},
      '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, '{32'h0000_0001, 1'b1, 1'b0}},
      '{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, '{32'h0001_0000, 1'b0, 1'b0}},
      '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, '{32'h0000_0000, 1'b1, 1'b0}},
      '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, '{32'h8000_0000, 1'b0, 1'b1}},
      '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, '{32'hFFFF_FFFF, 1'b1, 1'b0}},
      '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, '{32'hFFFF_FFFF, 1'b0, 1'b0}}
    };
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      clear();
      drive(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].sub, 1'b1);
      tick();
      drive_rand(1'b0);
      wait_results(1, 20);
      n_cmp++;
      if (got_q.size() != 1) begin
        n_bad++;
        $display("FAIL dir%0d_count got %0d results exp 1", i, got_q.size());
        continue;
      end
      n_cmp++;
      if (got_q[0] !== tbl[i].r) begin
        n_bad++;
        $display("FAIL dir%0d_result got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b", i,
                 got_q[0].s, got_q[0].c, got_q[0].ovf, tbl[i].r.s, tbl[i].r.c, tbl[i].r.ovf);
      end
      n_cmp++;
      if (out_cyc[0] - acc_cyc[0] != NST) begin
        n_bad++;
        $display("FAIL dir%0d_latency got %0d exp %0d", i, out_cyc[0] - acc_cyc[0], NST);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear();
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'(i % 2), 1'b1);
      tick();
    end
    drive_rand(1'b0);
    wait_results(10, 30);
    for (int k = 0; k < 3; k++) begin
      drive_rand(1'b0);
      tick();
    end
    n_cmp++;
    if (got_q.size() != 10) begin
      n_bad++;
      $display("FAIL b2b_count got %0d exp 10", got_q.size());
      return;
    end
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i] || out_cyc[i] - acc_cyc[i] != NST || out_cyc[i] != out_cyc[0] + i) begin
        n_bad++;
        $display("FAIL b2b%0d got s=%h c=%b ovf=%b lat=%0d exp s=%h c=%b ovf=%b lat=%0d", i,
                 got_q[i].s, got_q[i].c, got_q[i].ovf, out_cyc[i] - acc_cyc[i],
                 exp_q[i].s, exp_q[i].c, exp_q[i].ovf, NST);
      end
    end
    // After the stream drains the outputs keep the last result.
    n_cmp++;
    if (bus.o_vld !== 1'b0 || res_t'({bus.o_s, bus.o_c, bus.o_ovf}) !== exp_q[9]) begin
      n_bad++;
      $display("FAIL b2b_idle_hold got vld=%b s=%h exp vld=0 s=%h", bus.o_vld, bus.o_s, exp_q[9].s);
    end
  endtask

  task automatic test_backpressure();
    clear();
    bus.i_rdy = 1'b0;
    for (int i = 0; i < NST; i++) begin
      drive_rand(1'b1);
      tick();
    end
    drive_rand(1'b1);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (bus.o_rdy !== 1'b0 || bus.o_vld !== 1'b1 ||
          res_t'({bus.o_s, bus.o_c, bus.o_ovf}) !== exp_q[0]) begin
        n_bad++;
        $display("FAIL bp_hold%0d got rdy=%b vld=%b s=%h exp rdy=0 vld=1 s=%h",
                 k, bus.o_rdy, bus.o_vld, bus.o_s, exp_q[0].s);
      end
      tick();
    end
    drive_rand(1'b0);
    bus.i_rdy = 1'b1;
    wait_results(NST, 20);
    for (int k = 0; k < 6; k++) tick();
    n_cmp++;
    if (got_q.size() != NST || exp_q.size() != NST) begin
      n_bad++;
      $display("FAIL bp_count got %0d results for %0d accepted exp %0d", got_q.size(), exp_q.size(), NST);
      return;
    end
    for (int i = 0; i < NST; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL bp%0d got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b", i,
                 got_q[i].s, got_q[i].c, got_q[i].ovf, exp_q[i].s, exp_q[i].c, exp_q[i].ovf);
      end
    end
  endtask

  task automatic test_random_flow();
    clear();
    for (int k = 0; k < 80; k++) begin
      drive_rand(1'($urandom_range(0, 3) != 0));
      bus.i_rdy = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    drive_rand(1'b0);
    bus.i_rdy = 1'b1;
    wait_results(exp_q.size(), 40);
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL flow_count got %0d exp %0d", got_q.size(), exp_q.size());
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_bad++;
        $display("FAIL flow%0d got s=%h c=%b ovf=%b exp s=%h c=%b ovf=%b", i,
                 got_q[i].s, got_q[i].c, got_q[i].ovf, exp_q[i].s, exp_q[i].c, exp_q[i].ovf);
      end
    end
  endtask

  task automatic test_reset_mid();
    res_t expected;
    clear();
    bus.i_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      tick();
    end
    drive_rand(1'b0);
    rst = 1'b1;
    tick();
    n_cmp++;
    if (bus.o_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_o_vld got %b exp 0", bus.o_vld);
    end
    rst = 1'b0;
    clear();
    for (int k = 0; k < 8; k++) tick();
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++;
      $display("FAIL rstmid_discard got %0d results exp 0", got_q.size());
    end
    drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
    expected = '{32'h2222_2222, 1'b0, 1'b0};
    tick();
    drive_rand(1'b0);
    wait_results(1, 20);
    n_cmp++;
    if (got_q.size() != 1 || got_q[0] !== expected || out_cyc[0] - acc_cyc[0] != NST) begin
      n_bad++;
      $display("FAIL rstmid_after got %0d results s=%h lat=%0d exp 1 result s=%h lat=%0d",
               got_q.size(), got_q.size() > 0 ? got_q[0].s : 32'h0,
               got_q.size() > 0 ? out_cyc[0] - acc_cyc[0] : -1, expected.s, NST);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.i_rdy = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_flow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_cla_pipe.md
Name: adder_cla_pipe

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It succeeds the 32-bit single-cycle combinational CLA adder.
- The BW_DATA operand is split into NSTAGE equal segments. Segment k is added in pipeline stage k, and the carry is registered between stages.
- Upper operand segments are skewed through the pipe so timing closes at high clock rates.
- Valid/ready handshakes on both sides. Sits in datapaths as a drop-in arithmetic unit.

Parameters:
BW_DATA, 32, operand/result width; must be a multiple of NSTAGE.
NSTAGE, 4, pipeline stages = latency in cycles; 1..BW_DATA/BW_GRP.
BW_GRP, 4, CLA group width inside a segment; must divide BW_DATA/NSTAGE.

Ports:
i_clk  input  1  clock, rising edge.
i_rst  input  1  synchronous, active-high reset.
i_vld  input  1  input operands valid.
o_rdy  output  1  block can accept input this cycle.
i_a  input  BW_DATA  operand A.
i_b  input  BW_DATA  operand B.
i_c  input  1  carry-in (add) / borrow-in (sub).
i_sub  input  1  0 = add, 1 = subtract.
o_vld  output  1  result valid.
i_rdy  input  1  downstream accepts result.
o_s  output  BW_DATA  sum/difference.
o_c  output  1  carry-out (for sub: 1 = no borrow).
o_ovf  output  1  signed (two's-complement) overflow.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-high on i_rst.
- Reset values: all stage valid bits are 0. o_vld=0, o_s=0, o_c=0, o_ovf=0. o_rdy=1 in the first cycle after reset deasserts.
- Operand conditioning:
  - effective B = i_sub ? ~i_b : i_b.
  - effective carry-in = i_c ^ i_sub.
  - So sub with i_c=0 gives A−B, and i_c=1 gives A−B−1.
- Arithmetic:
  - Modulo 2^BW_DATA. o_c is the carry out of the MSB.
  - o_ovf = (A[MSB] == effB[MSB]) && (S[MSB] != A[MSB]).
- Global enable: en = !o_vld || i_rdy, and o_rdy = en.
  - An input transfer occurs when i_vld && o_rdy.
  - An output transfer occurs when o_vld && i_rdy.
- Pipeline, per stage:
  - Stage k computes segment k with BW_GRP lookahead groups from the registered carry of stage k−1.
  - It passes forward: finished low segments, unprocessed high segments of A/effB, carry, sign info and valid.
  - All stage registers update only when en=1. When en=0, every stage, including the output, holds.
- Timing:
  - Latency is exactly NSTAGE cycles from input transfer to o_vld, with no stall.
  - Throughput is 1 result per cycle. Results leave in acceptance order, with no loss or duplication.
- Bubbles: when i_vld=0 and en=1, a bubble (valid=0) enters. Bubbles are not compressed.
- Output hold: while o_vld && !i_rdy, o_s/o_c/o_ovf/o_vld are stable. When o_vld=0, o_s/o_c/o_ovf hold their last values.
- Simultaneous input and output transfer in the same cycle is legal. The pipe advances by one.
- Reset mid-operation: in-flight results are discarded, never emitted. The reset values above apply on the next edge regardless of i_vld/i_rdy.
- NSTAGE=1: a single registered full-width CLA with latency 1.
- Invalid parameter combinations cause an elaboration-time error via a generate-block check.

Decomposition:
- Shared header adder_cla_defs.vh holds:
  - default BW_DATA/NSTAGE/BW_GRP;
  - the derived BW_SEG = BW_DATA/NSTAGE;
  - the mode encodings MODE_ADD=0 and MODE_SUB=1.
- One combinational sub-module, cla_seg, instantiated NSTAGE times:
  - inputs: BW_SEG-wide a, b, cin;
  - outputs: s, cout, and msb-carry-in for the overflow calculation;
  - internally: generate/propagate per BW_GRP group with group lookahead.
- adder_cla_pipe holds only the skew registers, the valid chain and the enable logic.

Test Plan:
1. i_rst=1 for 2 cycles with i_vld=1, i_a=5, i_b=3 -> o_vld stays 0, o_s=0, o_c=0, o_ovf=0; nothing emitted after release.
2. Add with a full carry ripple: 0xFFFFFFFF + 0x00000001, i_c=0, i_sub=0 -> 4 cycles later o_vld=1, o_s=0x00000000, o_c=1, o_ovf=0.
3. Subtract cases:
   - 0x00000005 − 0x00000007, i_c=0 -> o_s=0xFFFFFFFE, o_c=0, o_ovf=0.
   - 0x80000000 − 0x00000001 -> o_s=0x7FFFFFFF, o_c=1, o_ovf=1.
   - 0x7FFFFFFF + 0x00000001, add -> o_s=0x80000000, o_ovf=1.
4. Streaming: 10 back-to-back random vectors (file-driven, with both i_sub values), i_rdy=1 -> results on 10 consecutive cycles starting at cycle 4, in order, matching the reference model.
5. Backpressure: pipe full, i_rdy=0 for 3 cycles -> o_rdy=0, o_vld=1 with o_s stable. After release, all 4 in-flight results are emitted once each, in order.
6. Reset mid-operation: 3 vectors in flight, i_rst pulsed 1 cycle -> o_vld=0 from the next edge, none of the 3 results ever appear. A new vector after release returns at latency 4.
